// File: rtl/pe_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pe_cmd_sequencer
// Brief    : Issues RESET / SET_CONV_MODE / TRIGGER* commands to one PE for a
//            dot-product job and returns the PE accumulator on a result port.
// Revision : 1.0
// ============================================================================
module pe_cmd_sequencer #(
    parameter int ACLEN      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [LEN_WIDTH-1:0]  job_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0] in_weight,
    output logic                  pe_cmd_valid,
    output logic [ACLEN:0]        pe_cmd,
    output logic [DATA_WIDTH-1:0] pe_param_1,
    output logic [DATA_WIDTH-1:0] pe_param_2,
    output logic [DATA_WIDTH-1:0] pe_data,
    output logic [DATA_WIDTH-1:0] pe_weight,
    input  logic                  pe_busy,
    input  logic [DATA_WIDTH-1:0] pe_mac_value,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_timeout
);

    localparam int CMD_WIDTH  = ACLEN + 1;
    localparam int WAIT_WIDTH = $clog2(TIMEOUT + 1);

    localparam logic [ACLEN:0] CMD_RESET    = CMD_WIDTH'(0);
    localparam logic [ACLEN:0] CMD_TRIGGER  = CMD_WIDTH'(1);
    localparam logic [ACLEN:0] CMD_LAST     = CMD_WIDTH'(2);
    localparam logic [ACLEN:0] CMD_SET_CONV = CMD_WIDTH'(6);

    // PE busy only becomes meaningful one cycle after the final trigger lands
    localparam logic [WAIT_WIDTH-1:0] BUSY_SETTLE = WAIT_WIDTH'(2);
    localparam logic [WAIT_WIDTH-1:0] WAIT_LAST   = WAIT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_CFG    = 3'd2,
        S_STREAM = 3'd3,
        S_WAIT   = 3'd4,
        S_RESULT = 3'd5
    } state_t;

    state_t                  state, state_nxt;
    logic [LEN_WIDTH-1:0]    len, len_nxt;
    logic [LEN_WIDTH-1:0]    sent, sent_nxt;
    logic [WAIT_WIDTH-1:0]   wait_cnt, wait_nxt;
    logic                    cmd_valid_nxt;
    logic [ACLEN:0]          cmd_nxt;
    logic [DATA_WIDTH-1:0]   param_1_nxt;
    logic [DATA_WIDTH-1:0]   data_nxt;
    logic [DATA_WIDTH-1:0]   weight_nxt;
    logic                    res_valid_nxt;
    logic [DATA_WIDTH-1:0]   res_data_nxt;
    logic                    res_timeout_nxt;
    logic                    last_beat;

    assign pe_param_2 = '0;
    assign last_beat  = (sent == len - LEN_WIDTH'(1));

    always_comb begin
        state_nxt       = state;
        len_nxt         = len;
        sent_nxt        = sent;
        wait_nxt        = wait_cnt;
        cmd_valid_nxt   = 1'b0;
        cmd_nxt         = CMD_RESET;
        param_1_nxt     = '0;
        data_nxt        = pe_data;
        weight_nxt      = pe_weight;
        res_valid_nxt   = res_valid;
        res_data_nxt    = res_data;
        res_timeout_nxt = res_timeout;

        case (state)
            S_IDLE: begin
                if (job_valid && job_ready) begin
                    len_nxt  = job_len;
                    sent_nxt = '0;
                    wait_nxt = '0;
                    if (job_len == '0) begin
                        state_nxt       = S_RESULT;
                        res_valid_nxt   = 1'b1;
                        res_data_nxt    = '0;
                        res_timeout_nxt = 1'b0;
                    end else begin
                        state_nxt     = S_CLR;
                        cmd_valid_nxt = 1'b1;
                        cmd_nxt       = CMD_RESET;
                    end
                end
            end
            S_CLR: begin
                state_nxt     = S_CFG;
                cmd_valid_nxt = 1'b1;
                cmd_nxt       = CMD_SET_CONV;
                param_1_nxt   = DATA_WIDTH'(len);
            end
            S_CFG: begin
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (in_valid && in_ready) begin
                    cmd_valid_nxt = 1'b1;
                    data_nxt      = in_data;
                    weight_nxt    = in_weight;
                    sent_nxt      = sent + LEN_WIDTH'(1);
                    if (last_beat) begin
                        cmd_nxt   = CMD_LAST;
                        state_nxt = S_WAIT;
                        wait_nxt  = '0;
                    end else begin
                        cmd_nxt   = CMD_TRIGGER;
                    end
                end
            end
            S_WAIT: begin
                wait_nxt = wait_cnt + WAIT_WIDTH'(1);
                if (wait_cnt >= BUSY_SETTLE && !pe_busy) begin
                    state_nxt       = S_RESULT;
                    res_valid_nxt   = 1'b1;
                    res_data_nxt    = pe_mac_value;
                    res_timeout_nxt = 1'b0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt       = S_RESULT;
                    res_valid_nxt   = 1'b1;
                    res_data_nxt    = '0;
                    res_timeout_nxt = 1'b1;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_nxt       = S_IDLE;
                    res_valid_nxt   = 1'b0;
                    res_timeout_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Handshake readies are registered from the next state so they track state exactly
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            len          <= '0;
            sent         <= '0;
            wait_cnt     <= '0;
            job_ready    <= 1'b0;
            in_ready     <= 1'b0;
            pe_cmd_valid <= 1'b0;
            pe_cmd       <= '0;
            pe_param_1   <= '0;
            pe_data      <= '0;
            pe_weight    <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_timeout  <= 1'b0;
        end else begin
            state        <= state_nxt;
            len          <= len_nxt;
            sent         <= sent_nxt;
            wait_cnt     <= wait_nxt;
            job_ready    <= (state_nxt == S_IDLE);
            in_ready     <= (state_nxt == S_STREAM);
            pe_cmd_valid <= cmd_valid_nxt;
            pe_cmd       <= cmd_nxt;
            pe_param_1   <= param_1_nxt;
            pe_data      <= data_nxt;
            pe_weight    <= weight_nxt;
            res_valid    <= res_valid_nxt;
            res_data     <= res_data_nxt;
            res_timeout  <= res_timeout_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_cmd_sequencer
// Brief    : Scoreboard bench for pe_cmd_sequencer with a behavioural PE model.
// Revision : 1.0
// ============================================================================
module tb_pe_cmd_sequencer;

    localparam int ACLEN = 8;
    localparam int DW    = 32;
    localparam int LW    = 16;

    localparam logic [ACLEN:0] OP_RESET = 9'd0;
    localparam logic [ACLEN:0] OP_TRIG  = 9'd1;
    localparam logic [ACLEN:0] OP_LAST  = 9'd2;
    localparam logic [ACLEN:0] OP_CONV  = 9'd6;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           job_valid;
    logic           job_ready;
    logic [LW-1:0]  job_len;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic [DW-1:0]  in_weight;
    logic           pe_cmd_valid;
    logic [ACLEN:0] pe_cmd;
    logic [DW-1:0]  pe_param_1;
    logic [DW-1:0]  pe_param_2;
    logic [DW-1:0]  pe_data;
    logic [DW-1:0]  pe_weight;
    logic           pe_busy;
    logic [DW-1:0]  pe_mac_value;
    logic           res_valid;
    logic           res_ready;
    logic [DW-1:0]  res_data;
    logic           res_timeout;

    typedef struct {
        logic [ACLEN:0] cmd;
        logic [DW-1:0]  p1;
        logic [DW-1:0]  data;
        logic [DW-1:0]  weight;
        bit             dw;
    } cmd_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          timeout;
    } res_t;

    cmd_t          exp_q[$];
    res_t          res_q[$];
    cmd_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_mac;
    bit            stuck;
    logic          model_busy;
    int            busy_cnt;
    logic [DW-1:0] model_mac;

    pe_cmd_sequencer #(
        .ACLEN(ACLEN), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT(1023)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
        .pe_cmd_valid(pe_cmd_valid), .pe_cmd(pe_cmd), .pe_param_1(pe_param_1),
        .pe_param_2(pe_param_2), .pe_data(pe_data), .pe_weight(pe_weight),
        .pe_busy(pe_busy), .pe_mac_value(pe_mac_value),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_timeout(res_timeout)
    );

    always #5 clk_i = ~clk_i;

    // PE model: busy one cycle after any trigger, clears 5 cycles after the last one
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            model_busy <= 1'b0;
            busy_cnt   <= 0;
            model_mac  <= '0;
        end else if (pe_cmd_valid && (pe_cmd == OP_TRIG || pe_cmd == OP_LAST)) begin
            model_busy <= 1'b1;
            busy_cnt   <= 5;
            model_mac  <= model_mac + (pe_data ^ pe_weight);
        end else begin
            if (pe_cmd_valid && pe_cmd == OP_RESET) model_mac <= '0;
            if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) model_busy <= 1'b0;
            end
        end
    end

    assign pe_busy      = model_busy | stuck;
    assign pe_mac_value = model_mac;

    always @(negedge clk_i) begin
        if (rst_ni && pe_cmd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pe_cmd_unexpected: got cmd=%0d p1=%h, required no command", pe_cmd, pe_param_1);
            end else begin
                mon_e = exp_q.pop_front();
                if (pe_cmd !== mon_e.cmd || pe_param_1 !== mon_e.p1 || pe_param_2 !== '0 ||
                    (mon_e.dw && (pe_data !== mon_e.data || pe_weight !== mon_e.weight))) begin
                    errors++;
                    $display("FAIL pe_cmd: got cmd=%0d p1=%h p2=%h data=%h weight=%h, required cmd=%0d p1=%h p2=0 data=%h weight=%h",
                             pe_cmd, pe_param_1, pe_param_2, pe_data, pe_weight,
                             mon_e.cmd, mon_e.p1, mon_e.data, mon_e.weight);
                end
            end
        end
    end

    task automatic push_cmd(input logic [ACLEN:0] c, input logic [DW-1:0] p1,
                            input logic [DW-1:0] d, input logic [DW-1:0] w, input bit dw);
        cmd_t e;
        e.cmd = c; e.p1 = p1; e.data = d; e.weight = w; e.dw = dw;
        exp_q.push_back(e);
    endtask

    task automatic push_res(input logic [DW-1:0] d, input logic t);
        res_t e;
        e.data = d; e.timeout = t;
        res_q.push_back(e);
    endtask

    task automatic start_job(input int n);
        int c;
        c = 0;
        while (!job_ready && c < 50) begin @(posedge clk_i); #1; c++; end
        checks++;
        if (job_ready !== 1'b1) begin
            errors++;
            $display("FAIL job_ready_wait: job_ready=%b, required 1", job_ready);
        end
        exp_mac = '0;
        if (n > 0) begin
            push_cmd(OP_RESET, '0, '0, '0, 1'b0);
            push_cmd(OP_CONV, DW'(n), '0, '0, 1'b0);
        end
        job_valid = 1'b1;
        job_len   = LW'(n);
        @(posedge clk_i); #1;
        job_valid = 1'b0;
    endtask

    task automatic stream(input int n, input logic [7:0] pat, input int plen);
        int beats; int k; int cyc;
        logic v;
        logic [DW-1:0] d, w;
        beats = 0; k = 0; cyc = 0;
        while (beats < n && cyc < 300) begin
            v = pat[k % plen];
            d = $urandom;
            w = $urandom;
            in_valid = v; in_data = d; in_weight = w;
            if (in_ready) begin
                if (v) begin
                    push_cmd((beats == n - 1) ? OP_LAST : OP_TRIG, '0, d, w, 1'b1);
                    exp_mac = exp_mac + (d ^ w);
                    beats++;
                end
                k++;
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (beats != n) begin
            errors++;
            $display("FAIL stream_beats: accepted %0d, required %0d", beats, n);
        end
    endtask

    task automatic wait_result(input int hold, input bit poke);
        int c;
        res_t e;
        c = 0;
        e.data = '0; e.timeout = 1'b0;
        while (!res_valid && c < 2000) begin @(posedge clk_i); #1; c++; end
        if (res_q.size() > 0) e = res_q.pop_front();
        checks++;
        if (res_valid !== 1'b1 || res_data !== e.data || res_timeout !== e.timeout) begin
            errors++;
            $display("FAIL result: got valid=%b data=%h timeout=%b, required valid=1 data=%h timeout=%b",
                     res_valid, res_data, res_timeout, e.data, e.timeout);
        end
        if (poke) begin job_valid = 1'b1; job_len = LW'(7); end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i); #1;
            checks++;
            if (res_valid !== 1'b1 || res_data !== e.data || job_ready !== 1'b0) begin
                errors++;
                $display("FAIL result_hold: got valid=%b data=%h job_ready=%b, required valid=1 data=%h job_ready=0",
                         res_valid, res_data, job_ready, e.data);
            end
        end
        job_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk_i); #1;
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || res_timeout !== 1'b0 || job_ready !== 1'b1) begin
            errors++;
            $display("FAIL result_accept: got valid=%b timeout=%b job_ready=%b, required 0 0 1",
                     res_valid, res_timeout, job_ready);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL cmd_missing: %0d commands outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({job_ready, in_ready, pe_cmd_valid, pe_cmd, pe_param_1, pe_param_2, pe_data,
             pe_weight, res_valid, res_data, res_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: job_ready=%b in_ready=%b cmd_valid=%b res_valid=%b, required all 0",
                     job_ready, in_ready, pe_cmd_valid, res_valid);
        end
        rst_ni = 1'b1;
        checks++;
        if (job_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_job_ready: got %b, required 0", job_ready);
        end
        @(posedge clk_i); #1;
        checks++;
        if (job_ready !== 1'b1 || in_ready !== 1'b0 || pe_cmd_valid !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: job_ready=%b in_ready=%b cmd_valid=%b res_valid=%b, required 1 0 0 0",
                     job_ready, in_ready, pe_cmd_valid, res_valid);
        end
    endtask

    task automatic test_basic;
        start_job(4);
        stream(4, 8'hFF, 1);
        push_res(exp_mac, 1'b0);
        wait_result(0, 1'b0);
    endtask

    task automatic test_stall;
        start_job(3);
        stream(3, 8'b0001_1001, 5);
        push_res(exp_mac, 1'b0);
        wait_result(0, 1'b0);
    endtask

    task automatic test_zero;
        int c;
        start_job(0);
        push_res('0, 1'b0);
        c = 0;
        while (!res_valid && c < 1) begin @(posedge clk_i); #1; c++; end
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL zero_len_latency: res_valid=%b after 2 cycles, required 1", res_valid);
        end
        wait_result(0, 1'b0);
    endtask

    task automatic test_timeout;
        int c;
        stuck = 1'b1;
        start_job(2);
        stream(2, 8'h01, 1);
        push_res('0, 1'b1);
        c = 0;
        while (!res_valid && c < 1100) begin @(posedge clk_i); #1; c++; end
        checks++;
        if (c != 1023) begin
            errors++;
            $display("FAIL timeout_cycles: result after %0d WAIT cycles, required 1023", c);
        end
        wait_result(0, 1'b0);
        stuck = 1'b0;
    endtask

    task automatic test_backpressure;
        start_job(3);
        stream(3, 8'h01, 1);
        push_res(exp_mac, 1'b0);
        wait_result(10, 1'b1);
    endtask

    task automatic test_reset_mid;
        int c;
        logic [DW-1:0] d, w;
        start_job(5);
        c = 0;
        while (!in_ready && c < 20) begin @(posedge clk_i); #1; c++; end
        d = $urandom; w = $urandom;
        in_valid = 1'b1; in_data = d; in_weight = w;
        push_cmd(OP_TRIG, '0, d, w, 1'b1);
        @(posedge clk_i); #1;
        in_data = $urandom; in_weight = $urandom;
        @(negedge clk_i); #1;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({job_ready, in_ready, pe_cmd_valid, pe_cmd, pe_param_1, pe_data, pe_weight,
             res_valid, res_data, res_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_async: job_ready=%b in_ready=%b cmd_valid=%b cmd=%0d data=%h res_valid=%b, required all 0",
                     job_ready, in_ready, pe_cmd_valid, pe_cmd, pe_data, res_valid);
        end
        in_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_cmds: %0d commands outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        start_job(1);
        stream(1, 8'h01, 1);
        push_res(exp_mac, 1'b0);
        wait_result(0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni    = 1'b0;
        job_valid = 1'b0;
        job_len   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_weight = '0;
        res_ready = 1'b0;
        stuck     = 1'b0;
        exp_mac   = '0;
        test_reset;
        test_basic;
        test_stall;
        test_zero;
        test_timeout;
        test_backpressure;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
